key_onehot_capture: RTL and testbench
=====================================

# key_onehot_capture

Upstream front end for the 4-to-2 binary encoder. Synchronises and debounces four raw key inputs and turns each debounced press into a queued event. It presents the events one at a time as a strictly one-hot 4-bit word with a valid/ready handshake. The encoder's `din` therefore only ever sees 0000 or a single set bit, never multi-hot codes such as 1100 or 0110.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive cycles a synchronised level must differ from the stable level before it is accepted. Legal range is 1..255.
- `SYNC_STAGES`, default 2: synchroniser depth per key. Legal range is 2..3.
- `clk`, input, 1: the single clock. All flops are on its rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `key_raw`, input, 4: asynchronous key levels, 1 = pressed. Bit i is key i.
- `onehot_out`, output, 4: current event, one-hot. Drives the encoder `din`. It is 0000 whenever `valid_out` = 0.
- `valid_out`, output, 1: `onehot_out` holds an event.
- `ready_in`, input, 1: consumer accepts the event on a cycle where `valid_out` & `ready_in`.
- `overrun`, output, 1: one-cycle pulse when a press is dropped.

## Operation
- **Per key:** `key_raw[i]` passes through a `SYNC_STAGES` flop chain to give `sync[i]`.
- **Debounce counter per key:** width is $clog2(DEBOUNCE_CYCLES+1).
  - When `sync` == `stable`, the counter is set to 0.
  - When `sync` != `stable` and counter == DEBOUNCE_CYCLES-1, `stable` takes `sync` and the counter is set to 0.
  - Otherwise the counter increments.
  - A glitch shorter than DEBOUNCE_CYCLES cycles is never accepted.
- **Press event:** the same-edge 0→1 update of `stable[i]`. Releases (1→0) generate nothing.
- **Pending mask, 4 bits:** a press sets `pending[i]`.
  - If `pending[i]` is already 1 and is not being cleared on that edge, the press is dropped and `overrun` pulses high for one cycle.
  - A press on the key currently shown on `onehot_out` is queued normally.
- **Arbitration:** the lowest-index pending bit wins.
- **FSM states:**
  - IDLE: `valid_out` = 0. If pending != 0, load the winner into `onehot_out`, clear that pending bit, and go to HOLD.
  - HOLD: `valid_out` = 1 and `onehot_out` is stable.
    - On `ready_in`, if pending != 0, load the next winner and stay in HOLD. This gives back-to-back events with no bubble.
    - On `ready_in` with pending == 0, clear `onehot_out`, deassert `valid_out`, and go to IDLE.
    - Without `ready_in`, hold indefinitely.
- **Simultaneous clear and set of the same pending bit:** the bit stays 1 and there is no overrun.
- **Reset values:**
  - Sync flops, `stable`, counters and pending are all 0.
  - FSM is in IDLE.
  - `onehot_out` = 0000, `valid_out` = 0, `overrun` = 0.
  - Keys are taken as released at reset, so a key held through reset produces one press after release of `rst_n`.
- **Reset mid-operation** discards pending and held events immediately (asynchronous).

## Timing
- A clean press reaches `sync` after SYNC_STAGES edges.
- `stable` and `pending` update DEBOUNCE_CYCLES edges later.
- `valid_out` and `onehot_out` update on the following edge.
- Total latency is SYNC_STAGES + DEBOUNCE_CYCLES + 1 rising edges from the first edge sampling the new level. With defaults this is 7.
- The handshake completes on the edge where `valid_out` & `ready_in`. The next event, if pending, is visible after that same edge.
- `valid_out` never drops without a handshake, and `onehot_out` never changes while `valid_out` & !`ready_in`.
- Sustained throughput is one event per cycle while `ready_in` = 1.
- All outputs are registered. There is no combinational path from `ready_in` or `key_raw` to any output.

## Structure
- Package `key_capture_pkg` contains:
  - `NUM_KEYS` = 4.
  - `cap_state_t` enum {IDLE, HOLD}.
  - A lowest-set-bit one-hot function.
- Sub-module `key_debounce` is one channel: synchroniser, counter, `stable` register and `press` pulse output. It is instantiated NUM_KEYS times.
- The top level holds the pending mask, arbiter, FSM and output registers.

## Test plan
- **Single press:** hold `key_raw` = 0010, `ready_in` = 1. Expect `onehot_out` = 0010 with `valid_out` = 1 for exactly one cycle, 7 edges after the change, then 0000.
- **Glitch:** pulse `key_raw[0]` high for 3 cycles with DEBOUNCE_CYCLES = 4. Expect no `valid_out` and no `overrun`.
- **Simultaneous press:** apply `key_raw` = 1100 in one cycle, `ready_in` = 1. Expect 0100 then 1000 on consecutive cycles, never 1100.
- **Backpressure:** press keys 1, 2 and 3 with `ready_in` = 0 for 20 cycles. Expect `onehot_out` = 0010 to be held stable. Then raise `ready_in` and expect 0010, 0100, 1000 back-to-back.
- **Overrun:** with `ready_in` = 0, press key 2, release, and press it again twice. Expect one `overrun` pulse, and only two 0100 events after `ready_in` = 1.
- **Reset mid-hold:** assert `rst_n` = 0 while `valid_out` = 1 with events pending. Expect `valid_out` = 0 and `onehot_out` = 0000 immediately. After release, expect no events until a new debounced press.

Source files
------------

// File: rtl/key_onehot_capture_pkg.sv
// Shared definitions for the key capture front end: key count, FSM states
// and the lowest-set-bit arbiter used to pick the next event.
package key_capture_pkg;

  localparam int unsigned NUM_KEYS = 4;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } cap_state_t;

  // Isolates the lowest set bit; all-zero input yields all-zero output.
  function automatic logic [NUM_KEYS-1:0] lowest_onehot(input logic [NUM_KEYS-1:0] v);
    return v & (~v + NUM_KEYS'(1));
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One key channel: reset-to-released synchroniser, debounce counter, stable
// level register and a press pulse coincident with the stable 0->1 update.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic press
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic                   stable;
  logic                   stable_d;
  logic [CW-1:0]          cnt;
  logic [CW-1:0]          cnt_d;
  logic                   accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], key_raw};
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  // The level is accepted on the edge where it has differed for the full window.
  always_comb begin
    accept   = (sync != stable) && (cnt == LAST);
    stable_d = stable;
    cnt_d    = '0;
    if (accept) begin
      stable_d = sync;
    end else if (sync != stable) begin
      cnt_d = cnt + CW'(1);
    end
    press = accept & sync;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      stable <= stable_d;
      cnt    <= cnt_d;
    end
  end

endmodule

// File: rtl/key_onehot_capture.sv
// Debounced key press queue presenting one event at a time as a strictly
// one-hot word with valid/ready handshake and a registered overrun pulse.
module key_onehot_capture
  import key_capture_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_raw,
  output logic [NUM_KEYS-1:0] onehot_out,
  output logic                valid_out,
  input  logic                ready_in,
  output logic                overrun
);

  cap_state_t          state, state_d;
  logic [NUM_KEYS-1:0] press;
  logic [NUM_KEYS-1:0] pending, pending_d;
  logic [NUM_KEYS-1:0] winner;
  logic [NUM_KEYS-1:0] clr;
  logic [NUM_KEYS-1:0] onehot_q, onehot_d;
  logic [NUM_KEYS-1:0] drop;
  logic                overrun_q;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES)
    ) u_debounce (
      .clk    (clk),
      .rst_n  (rst_n),
      .key_raw(key_raw[i]),
      .press  (press[i])
    );
  end

  assign winner = lowest_onehot(pending);

  always_comb begin
    state_d  = state;
    onehot_d = onehot_q;
    clr      = '0;
    case (state)
      IDLE: begin
        if (|pending) begin
          onehot_d = winner;
          clr      = winner;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        if (ready_in) begin
          if (|pending) begin
            onehot_d = winner;
            clr      = winner;
          end else begin
            onehot_d = '0;
            state_d  = IDLE;
          end
        end
      end
      default: begin
        onehot_d = '0;
        state_d  = IDLE;
      end
    endcase
  end

  // A press landing on a bit being cleared this edge re-queues rather than drops.
  always_comb begin
    drop      = press & pending & ~clr;
    pending_d = (pending & ~clr) | press;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pending   <= '0;
      onehot_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      state     <= state_d;
      pending   <= pending_d;
      onehot_q  <= onehot_d;
      overrun_q <= |drop;
    end
  end

  assign onehot_out = onehot_q;
  assign valid_out  = (state == HOLD);
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_key_onehot_capture.sv
// Directed bench for key_onehot_capture with default debounce/sync depths.
module tb_key_onehot_capture;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] key_raw;
  logic [3:0] onehot_out;
  logic       valid_out;
  logic       ready_in;
  logic       overrun;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned vcnt   = 0;
  int unsigned ocnt   = 0;
  int unsigned multi  = 0;

  key_onehot_capture #(
    .DEBOUNCE_CYCLES(4),
    .SYNC_STAGES    (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_raw   (key_raw),
    .onehot_out(onehot_out),
    .valid_out (valid_out),
    .ready_in  (ready_in),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, sampling 1 time unit after each edge.
  task automatic step(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (valid_out) vcnt++;
      if (overrun) ocnt++;
      if ((onehot_out & (onehot_out - 4'd1)) != 4'd0) multi++;
      if (!valid_out && onehot_out != 4'd0) multi++;
    end
  endtask

  task automatic clr_counts();
    vcnt = 0;
    ocnt = 0;
  endtask

  initial begin
    rst_n    = 1'b0;
    key_raw  = 4'b0000;
    ready_in = 1'b0;
    step(3);
    chk("reset_valid",   {31'd0, valid_out}, 32'd0);
    chk("reset_onehot",  {28'd0, onehot_out}, 32'd0);
    chk("reset_overrun", {31'd0, overrun}, 32'd0);
    rst_n = 1'b1;
    step(3);

    // Single press: event visible 7 edges after the change, for one cycle.
    clr_counts();
    ready_in = 1'b1;
    key_raw  = 4'b0010;
    step(6);
    chk("single_early", vcnt, 32'd0);
    step(1);
    chk("single_valid",  {31'd0, valid_out}, 32'd1);
    chk("single_onehot", {28'd0, onehot_out}, 32'h2);
    step(1);
    chk("single_done_valid",  {31'd0, valid_out}, 32'd0);
    chk("single_done_onehot", {28'd0, onehot_out}, 32'h0);
    clr_counts();
    key_raw = 4'b0000;
    step(12);
    chk("release_no_event", vcnt, 32'd0);

    // Glitch of 3 cycles never accepted.
    clr_counts();
    key_raw = 4'b0001;
    step(3);
    key_raw = 4'b0000;
    step(15);
    chk("glitch_valid",   vcnt, 32'd0);
    chk("glitch_overrun", ocnt, 32'd0);

    // Simultaneous press is serialised lowest index first.
    key_raw = 4'b1100;
    step(7);
    chk("simul_first_valid", {31'd0, valid_out}, 32'd1);
    chk("simul_first",       {28'd0, onehot_out}, 32'h4);
    step(1);
    chk("simul_second_valid", {31'd0, valid_out}, 32'd1);
    chk("simul_second",       {28'd0, onehot_out}, 32'h8);
    step(1);
    chk("simul_done", {31'd0, valid_out}, 32'd0);
    key_raw = 4'b0000;
    step(12);

    // Backpressure: first event held stable, then drained back to back.
    ready_in = 1'b0;
    key_raw  = 4'b1110;
    step(7);
    chk("bp_valid",  {31'd0, valid_out}, 32'd1);
    chk("bp_onehot", {28'd0, onehot_out}, 32'h2);
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk("bp_hold", {27'd0, valid_out, onehot_out}, 32'h12);
    end
    ready_in = 1'b1;
    step(1);
    chk("bp_drain1", {27'd0, valid_out, onehot_out}, 32'h14);
    step(1);
    chk("bp_drain2", {27'd0, valid_out, onehot_out}, 32'h18);
    step(1);
    chk("bp_drain_end", {27'd0, valid_out, onehot_out}, 32'h00);
    key_raw = 4'b0000;
    step(12);

    // Overrun: three presses of key 2 while stalled; one is dropped.
    clr_counts();
    ready_in = 1'b0;
    key_raw  = 4'b0100;
    step(7);
    chk("ovr_held", {27'd0, valid_out, onehot_out}, 32'h14);
    key_raw = 4'b0000;
    step(8);
    key_raw = 4'b0100;
    step(8);
    key_raw = 4'b0000;
    step(8);
    key_raw = 4'b0100;
    step(8);
    chk("ovr_pulses", ocnt, 32'd1);
    chk("ovr_still_held", {27'd0, valid_out, onehot_out}, 32'h14);
    key_raw  = 4'b0000;
    ready_in = 1'b1;
    step(1);
    chk("ovr_second_event", {27'd0, valid_out, onehot_out}, 32'h14);
    step(1);
    chk("ovr_no_third", {27'd0, valid_out, onehot_out}, 32'h00);
    clr_counts();
    step(12);
    chk("ovr_quiet", vcnt, 32'd0);

    // Reset while holding with events pending.
    ready_in = 1'b0;
    key_raw  = 4'b1110;
    step(8);
    chk("rst_pre_valid", {31'd0, valid_out}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_async", {27'd0, valid_out, onehot_out}, 32'h00);
    key_raw = 4'b0000;
    step(3);
    rst_n    = 1'b1;
    ready_in = 1'b1;
    clr_counts();
    step(15);
    chk("rst_no_events", vcnt, 32'd0);
    key_raw = 4'b1000;
    step(7);
    chk("rst_new_press", {27'd0, valid_out, onehot_out}, 32'h18);
    key_raw = 4'b0000;
    step(12);

    // Key held through reset yields one press after release.
    key_raw = 4'b0001;
    rst_n   = 1'b0;
    step(3);
    rst_n = 1'b1;
    clr_counts();
    step(7);
    chk("held_thru_reset", {27'd0, valid_out, onehot_out}, 32'h11);
    step(10);
    chk("held_single_event", vcnt, 32'd1);

    chk("never_multi_hot", multi, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
